sprite_move_ctrl: RTL and testbench

Frame-synchronous position controller for the single square sprite drawn by the VGA pixel path. Arbitrates four active-low direction buttons and applies one clamped step per frame at vertical blank. Sits between the KEY inputs and the drawing logic, which consumes x_pos/y_pos/SIZE as the sprite's top-left corner and extent.

---
 rtl/sprite_move_ctrl_pkg.sv | 21 ++
 rtl/sprite_move_ctrl_key_sync.sv | 23 ++
 rtl/sprite_move_ctrl.sv | 136 +++++++++++++
 tb/tb_sprite_move_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_move_ctrl_pkg.sv
// Shared constants for the sprite movement controller: direction indices,
// FSM state encoding, default screen geometry and datapath widths.
package sprite_move_ctrl_pkg;

   localparam int unsigned KEY_W  = 4;
   localparam int unsigned POS_W  = 10;
   localparam int unsigned CALC_W = 11;

   localparam int unsigned DIR_UP    = 0;
   localparam int unsigned DIR_DOWN  = 1;
   localparam int unsigned DIR_RIGHT = 2;
   localparam int unsigned DIR_LEFT  = 3;

   localparam int unsigned SCREEN_H_ACT = 640;
   localparam int unsigned SCREEN_V_ACT = 480;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_ARB  = 2'd1;
   localparam logic [1:0] ST_MOVE = 2'd2;

endpackage

// File: rtl/sprite_move_ctrl_key_sync.sv
// Two-flop synchroniser for the raw active-low buttons; resets to released.
module sprite_move_ctrl_key_sync
   import sprite_move_ctrl_pkg::*;
(
   input  logic             CLOCK_50,
   input  logic             RESET_N,
   input  logic [KEY_W-1:0] key_n,
   output logic [KEY_W-1:0] key_sync
);

   logic [KEY_W-1:0] key_meta;

   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         key_meta <= '1;
         key_sync <= '1;
      end else begin
         key_meta <= key_n;
         key_sync <= key_meta;
      end
   end

endmodule

// File: rtl/sprite_move_ctrl.sv
// Frame-synchronous sprite position controller: arbitrates direction keys and
// applies one clamped step per frame. Define SPRITE_DIAG_EN for diagonal moves.
module sprite_move_ctrl
   import sprite_move_ctrl_pkg::*;
#(
   parameter int unsigned H_ACT      = SCREEN_H_ACT,
   parameter int unsigned V_ACT      = SCREEN_V_ACT,
   parameter int unsigned SIZE       = 50,
   parameter int unsigned STEP       = 3,
   parameter int unsigned X_INIT     = 300,
   parameter int unsigned Y_INIT     = 220,
   parameter int unsigned REPEAT_DLY = 0
)(
   input  logic             CLOCK_50,
   input  logic             RESET_N,
   input  logic             enable,
   input  logic             frame_tick,
   input  logic [KEY_W-1:0] key_n,
   output logic [POS_W-1:0] x_pos,
   output logic [POS_W-1:0] y_pos,
   output logic [KEY_W-1:0] grant,
   output logic             moving
);

   localparam int unsigned X_MAX  = H_ACT - 1 - SIZE;
   localparam int unsigned Y_MAX  = V_ACT - 1 - SIZE;
   localparam int unsigned HOLD_W = (REPEAT_DLY > 0) ? $clog2(REPEAT_DLY + 1) : 1;
   localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(REPEAT_DLY);

   logic [KEY_W-1:0]  key_sync;
   logic [KEY_W-1:0]  pressed;
   logic [KEY_W-1:0]  winner;
   logic [1:0]        state,    state_nxt;
   logic [POS_W-1:0]  x_nxt,    y_nxt;
   logic [KEY_W-1:0]  grant_nxt;
   logic              moving_nxt;
   logic [HOLD_W-1:0] hold_cnt, hold_nxt;
   logic [CALC_W-1:0] x_ext, y_ext, x_sum, y_sum;
   logic [POS_W-1:0]  x_left, x_right, y_up, y_down;

   sprite_move_ctrl_key_sync u_key_sync (
      .CLOCK_50 (CLOCK_50),
      .RESET_N  (RESET_N),
      .key_n    (key_n),
      .key_sync (key_sync)
   );

   assign pressed = ~key_sync;

   // Direction arbiter: left > right > down > up, or one winner per axis.
   always_comb begin
      winner = '0;
`ifdef SPRITE_DIAG_EN
      if (pressed[DIR_LEFT])       winner[DIR_LEFT]  = 1'b1;
      else if (pressed[DIR_RIGHT]) winner[DIR_RIGHT] = 1'b1;
      if (pressed[DIR_UP])         winner[DIR_UP]    = 1'b1;
      else if (pressed[DIR_DOWN])  winner[DIR_DOWN]  = 1'b1;
`else
      if (pressed[DIR_LEFT])       winner[DIR_LEFT]  = 1'b1;
      else if (pressed[DIR_RIGHT]) winner[DIR_RIGHT] = 1'b1;
      else if (pressed[DIR_DOWN])  winner[DIR_DOWN]  = 1'b1;
      else if (pressed[DIR_UP])    winner[DIR_UP]    = 1'b1;
`endif
   end

   // Clamped candidate positions; the extra bit keeps the sums from wrapping.
   assign x_ext   = CALC_W'(x_pos);
   assign y_ext   = CALC_W'(y_pos);
   assign x_sum   = x_ext + CALC_W'(STEP);
   assign y_sum   = y_ext + CALC_W'(STEP);
   assign x_left  = (x_ext >= CALC_W'(STEP)) ? POS_W'(x_ext - CALC_W'(STEP)) : '0;
   assign y_up    = (y_ext >= CALC_W'(STEP)) ? POS_W'(y_ext - CALC_W'(STEP)) : '0;
   assign x_right = (x_sum > CALC_W'(X_MAX)) ? POS_W'(X_MAX) : POS_W'(x_sum);
   assign y_down  = (y_sum > CALC_W'(Y_MAX)) ? POS_W'(Y_MAX) : POS_W'(y_sum);

   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         state    <= ST_IDLE;
         x_pos    <= POS_W'(X_INIT);
         y_pos    <= POS_W'(Y_INIT);
         grant    <= '0;
         moving   <= 1'b0;
         hold_cnt <= '0;
      end else begin
         state    <= state_nxt;
         x_pos    <= x_nxt;
         y_pos    <= y_nxt;
         grant    <= grant_nxt;
         moving   <= moving_nxt;
         hold_cnt <= hold_nxt;
      end
   end

   // Next state and next register values; enable low parks the sprite at home.
   always_comb begin
      state_nxt  = state;
      x_nxt      = x_pos;
      y_nxt      = y_pos;
      grant_nxt  = grant;
      moving_nxt = 1'b0;
      hold_nxt   = hold_cnt;
      if (!enable) begin
         state_nxt = ST_IDLE;
         x_nxt     = POS_W'(X_INIT);
         y_nxt     = POS_W'(Y_INIT);
         grant_nxt = '0;
         hold_nxt  = '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (pressed == '0)   hold_nxt  = '0;
               else if (frame_tick) state_nxt = ST_ARB;
            end
            ST_ARB: begin
               grant_nxt = winner;
               if (winner != grant) hold_nxt = '0;
               state_nxt = ST_MOVE;
            end
            ST_MOVE: begin
               // hold_cnt saturates at HOLD_MAX, so equality covers ">=".
               if ((hold_cnt == '0) || (hold_cnt == HOLD_MAX)) begin
                  moving_nxt = 1'b1;
                  if (grant[DIR_LEFT])       x_nxt = x_left;
                  else if (grant[DIR_RIGHT]) x_nxt = x_right;
                  if (grant[DIR_UP])         y_nxt = y_up;
                  else if (grant[DIR_DOWN])  y_nxt = y_down;
               end
               if (hold_cnt != HOLD_MAX) hold_nxt = hold_cnt + HOLD_W'(1);
               state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sprite_move_ctrl.sv
// Directed bench for sprite_move_ctrl with an expected-move scoreboard.
module tb_sprite_move_ctrl;

   typedef struct {
      int         x;
      int         y;
      logic [3:0] g;
   } exp_t;

   logic       CLOCK_50 = 1'b0;
   logic       RESET_N;
   logic       enable;
   logic       frame_tick;
   logic [3:0] key_n1, key_n2;
   logic [9:0] x1, y1, x2, y2;
   logic [3:0] g1, g2;
   logic       m1, m2;

   int   checks = 0;
   int   errors = 0;
   exp_t q1[$];
   exp_t q2[$];
   int   mx, my, my2;
   logic [3:0] mg;

   always #5 CLOCK_50 = ~CLOCK_50;

   sprite_move_ctrl #(.REPEAT_DLY(0)) u_dut (
      .CLOCK_50 (CLOCK_50), .RESET_N (RESET_N), .enable (enable),
      .frame_tick (frame_tick), .key_n (key_n1),
      .x_pos (x1), .y_pos (y1), .grant (g1), .moving (m1)
   );

   sprite_move_ctrl #(.REPEAT_DLY(3)) u_dut_rpt (
      .CLOCK_50 (CLOCK_50), .RESET_N (RESET_N), .enable (enable),
      .frame_tick (frame_tick), .key_n (key_n2),
      .x_pos (x2), .y_pos (y2), .grant (g2), .moving (m2)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic logic [3:0] exp_win(input logic [3:0] p);
      logic [3:0] w;
      w = 4'b0000;
`ifdef SPRITE_DIAG_EN
      if (p[3]) w[3] = 1'b1; else if (p[2]) w[2] = 1'b1;
      if (p[0]) w[0] = 1'b1; else if (p[1]) w[1] = 1'b1;
`else
      if (p[3]) w = 4'b1000;
      else if (p[2]) w = 4'b0100;
      else if (p[1]) w = 4'b0010;
      else if (p[0]) w = 4'b0001;
`endif
      return w;
   endfunction

   task automatic set_keys(input logic [3:0] k1, input logic [3:0] k2);
      key_n1 = k1;
      key_n2 = k2;
      repeat (3) @(negedge CLOCK_50);
   endtask

   // One frame: pulse frame_tick, then match any move against the queues.
   task automatic frame(input bit e1, input bit e2, input bit release_keys);
      bit   s1 = 1'b0, s2 = 1'b0;
      exp_t e;
      @(negedge CLOCK_50);
      frame_tick = 1'b1;
      if (release_keys) key_n1 = 4'hF;
      @(negedge CLOCK_50);
      frame_tick = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         @(negedge CLOCK_50);
         if (m1) begin
            if (q1.size() == 0) chk("unexpected_move1", 32'd1, 32'd0);
            else begin
               e = q1.pop_front();
               chk("x1", 32'(x1), e.x);
               chk("y1", 32'(y1), e.y);
               chk("grant1", 32'(g1), 32'(e.g));
               chk("latency1", k, 32'd2);
            end
            s1 = 1'b1;
         end
         if (m2) begin
            if (q2.size() == 0) chk("unexpected_move2", 32'd1, 32'd0);
            else begin
               e = q2.pop_front();
               chk("x2", 32'(x2), e.x);
               chk("y2", 32'(y2), e.y);
               chk("grant2", 32'(g2), 32'(e.g));
               chk("latency2", k, 32'd2);
            end
            s2 = 1'b1;
         end
      end
      chk("move1_seen", 32'(s1), 32'(e1));
      chk("move2_seen", 32'(s2), 32'(e2));
      q1.delete();
      q2.delete();
   endtask

   // Model one granted frame for the REPEAT_DLY=0 instance and run it.
   task automatic move1(input int n, input bit release_keys);
      logic [3:0] p;
      for (int i = 0; i < n; i++) begin
         p  = ~key_n1;
         mg = exp_win(p);
         if (mg[3])      mx = (mx >= 3) ? mx - 3 : 0;
         else if (mg[2]) mx = (mx + 3 > 589) ? 589 : mx + 3;
         if (mg[0])      my = (my >= 3) ? my - 3 : 0;
         else if (mg[1]) my = (my + 3 > 429) ? 429 : my + 3;
         q1.push_back('{mx, my, mg});
         frame(1'b1, 1'b0, release_keys);
      end
   endtask

   task automatic chk_out1(input string tag);
      chk({tag, "_x"}, 32'(x1), mx);
      chk({tag, "_y"}, 32'(y1), my);
      chk({tag, "_g"}, 32'(g1), 32'(mg));
   endtask

   initial begin
      bit pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      RESET_N = 1'b0; enable = 1'b0; frame_tick = 1'b0;
      key_n1 = 4'hF; key_n2 = 4'hF;
      mx = 300; my = 220; mg = 4'b0000;
      repeat (2) @(negedge CLOCK_50);
      chk_out1("reset");
      chk("reset_moving", 32'(m1), 32'd0);
      chk("reset_y2", 32'(y2), 32'd220);
      RESET_N = 1'b1;
      enable  = 1'b1;

      // Idle frames with no keys.
      repeat (10) frame(1'b0, 1'b0, 1'b0);
      chk_out1("idle");

      // Right, then run into the right-hand bound.
      set_keys(4'b1011, 4'hF);
      move1(5, 1'b0);
      chk("x_after_5_right", 32'(x1), 32'd315);
      move1(92, 1'b0);
      chk("x_right_bound", 32'(x1), 32'd589);
      move1(1, 1'b0);
      chk("x_held_at_bound", 32'(x1), 32'd589);

      // Left+up together.
      set_keys(4'b0110, 4'hF);
      move1(1, 1'b0);
`ifdef SPRITE_DIAG_EN
      chk("combo_x", 32'(x1), 32'd586);
      chk("combo_y", 32'(y1), 32'd217);
      chk("combo_g", 32'(g1), 32'b1001);
`else
      chk("combo_x", 32'(x1), 32'd586);
      chk("combo_y", 32'(y1), 32'd220);
      chk("combo_g", 32'(g1), 32'b1000);
`endif

      // Left down to x=4, then into the left bound.
      set_keys(4'b0111, 4'hF);
      move1(194, 1'b0);
      chk("x_at_4", 32'(x1), 32'd4);
      move1(3, 1'b0);
      chk("x_left_bound", 32'(x1), 32'd0);

      // Enable drop sends the sprite home on the next edge.
      set_keys(4'b1011, 4'hF);
      move1(5, 1'b0);
      enable = 1'b0;
      @(negedge CLOCK_50);
      mx = 300; my = 220; mg = 4'b0000;
      chk_out1("disable");
      frame(1'b0, 1'b0, 1'b0);
      chk_out1("disabled_frame");
      enable = 1'b1;

      // Key released together with the tick still completes the move.
      move1(1, 1'b1);
      chk("release_x", 32'(x1), 32'd303);
      set_keys(4'b1011, 4'hF);
      move1(1, 1'b0);

      // Reset between ARB and MOVE: no move applied.
      @(negedge CLOCK_50);
      frame_tick = 1'b1;
      @(negedge CLOCK_50);
      frame_tick = 1'b0;
      @(negedge CLOCK_50);
      RESET_N = 1'b0;
      #1;
      mx = 300; my = 220; mg = 4'b0000;
      chk_out1("async_reset");
      chk("async_reset_moving", 32'(m1), 32'd0);
      @(negedge CLOCK_50);
      chk("reset_no_move_x", 32'(x1), 32'd300);
      chk("reset_no_move_moving", 32'(m1), 32'd0);
      RESET_N = 1'b1;
      set_keys(4'hF, 4'hF);

      // Auto-repeat instance: down held for six frames, then release/repress.
      my2 = 220;
      set_keys(4'hF, 4'b1101);
      for (int i = 0; i < 6; i++) begin
         if (pat[i]) begin
            my2 += 3;
            q2.push_back('{300, my2, 4'b0010});
         end
         frame(1'b0, pat[i], 1'b0);
      end
      chk("rpt_y_after_6", 32'(y2), 32'd232);
      set_keys(4'hF, 4'hF);
      frame(1'b0, 1'b0, 1'b0);
      set_keys(4'hF, 4'b1101);
      my2 += 3;
      q2.push_back('{300, my2, 4'b0010});
      frame(1'b0, 1'b1, 1'b0);
      frame(1'b0, 1'b0, 1'b0);
      chk("rpt_y_repress", 32'(y2), 32'd235);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
